grey_div_counter: RTL

- Parametrised successor to the fixed divide-by-7 Gray tick generator.
- Prescaler divides clk by a runtime-programmable ratio; each terminal count advances a GREY_W-bit Gray-code counter by one step.
- Adds enable, a ratio-load handshake and a wrap indication.
- Sits beside the Gray-code sync blocks and feeds the Gray bus to downstream clock-domain-crossing consumers.

---
 rtl/grey_div_counter_if.sv | 23 ++
 rtl/grey_div_counter.sv | 117 +++++++++++
 2 files changed

// File: rtl/grey_div_counter_if.sv
// Handshake/bus bundle for grey_div_counter: enable, ratio-load handshake and Gray outputs.
// The dir signal exists only when GREY_DIV_UPDOWN_EN is defined.
interface grey_div_counter_if #(
  parameter int DIV_W  = 8,
  parameter int GREY_W = 6
);
  logic              en;
  logic              div_load;
  logic [DIV_W-1:0]  div_val;
  logic              div_ack;
  logic              tick;
  logic [GREY_W-1:0] grey;
  logic              wrap;
`ifdef GREY_DIV_UPDOWN_EN
  logic              dir;

  modport master (output en, div_load, div_val, dir, input div_ack, tick, grey, wrap);
  modport slave  (input en, div_load, div_val, dir, output div_ack, tick, grey, wrap);
`else
  modport master (output en, div_load, div_val, input div_ack, tick, grey, wrap);
  modport slave  (input en, div_load, div_val, output div_ack, tick, grey, wrap);
`endif
endinterface

// File: rtl/grey_div_counter.sv
// Programmable prescaler driving a Gray-code tick counter with ratio-load handshake and wrap pulse.
// Optional macro GREY_DIV_UPDOWN_EN adds a dir input for counting backward through the sequence.
module grey_div_counter #(
  parameter int DIV_W       = 8,
  parameter int GREY_W      = 6,
  parameter int DIV_DEFAULT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  grey_div_counter_if.slave    bus
);

  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [DIV_W-1:0]  ratio_q, ratio_d;
  logic [DIV_W-1:0]  pval_q, pval_d;
  logic              pend_q, pend_d;
  logic [GREY_W-1:0] grey_q, grey_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;
  logic              ack_q, ack_d;

  logic              term;
  logic              idle_apply;
  logic [DIV_W-1:0]  load_val;
  logic [GREY_W-1:0] cur_bin;
  logic [GREY_W-1:0] step_bin;
  logic              step_wrap;

  function automatic logic [GREY_W-1:0] gray2bin(input logic [GREY_W-1:0] g);
    logic [GREY_W-1:0] b;
    b[GREY_W-1] = g[GREY_W-1];
    for (int i = GREY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GREY_W-1:0] bin2gray(input logic [GREY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    cur_bin = gray2bin(grey_q);
`ifdef GREY_DIV_UPDOWN_EN
    step_bin  = bus.dir ? (cur_bin - GREY_W'(1)) : (cur_bin + GREY_W'(1));
    step_wrap = bus.dir ? (cur_bin == '0) : (step_bin == '0);
`else
    step_bin  = cur_bin + GREY_W'(1);
    step_wrap = (step_bin == '0);
`endif
  end

  always_comb begin
    term       = bus.en && (presc_q == (ratio_q - DIV_W'(1)));
    // A ratio change is safe at a period boundary: a terminal, or stalled before any count.
    idle_apply = !bus.en && (presc_q == '0);
    load_val   = (bus.div_val == '0) ? DIV_W'(1) : bus.div_val;

    presc_d = presc_q;
    ratio_d = ratio_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    grey_d  = grey_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    ack_d   = 1'b0;

    if (bus.div_load) begin
      pend_d = 1'b1;
      pval_d = load_val;
    end

    if (bus.en) begin
      presc_d = term ? '0 : (presc_q + DIV_W'(1));
    end

    if (term) begin
      tick_d = 1'b1;
      grey_d = bin2gray(step_bin);
      wrap_d = step_wrap;
    end

    if ((term || idle_apply) && (bus.div_load || pend_q)) begin
      ratio_d = bus.div_load ? load_val : pval_q;
      pend_d  = 1'b0;
      ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      ratio_q <= DIV_W'(DIV_DEFAULT);
      pval_q  <= '0;
      pend_q  <= 1'b0;
      grey_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ratio_q <= ratio_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      grey_q  <= grey_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.grey    = grey_q;
  assign bus.wrap    = wrap_q;
  assign bus.div_ack = ack_q;

endmodule
